sv_kernel_accum: RTL

//  Consumes the pixel streams from the memory control stage (x_test, sv_load1, sv_load2, gated by !stall_MEM).

---
 rtl/sv_kernel_accum.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sv_kernel_accum.sv
// Two-lane SV kernel accumulator: linear dot product by default, squared Euclidean distance
// when SV_KERNEL_SQ_DIST_EN is defined. Results leave through a valid/ready output register.
//
// state | meaning
// IDLE  | waiting for en
// ACCUM | accepting pixel beats, emitting one kern pair per NUM_OF_PIXELS beats
// DRAIN | last pair loaded, waiting for it to be consumed
// DONE  | one-cycle done pulse
module sv_kernel_accum #(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 4,
  parameter int NUM_OF_SV     = 10,
  parameter int ACC_W         = 20,
  parameter int IDX_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN_PIXEL-1:0] x_test,
  input  logic [XLEN_PIXEL-1:0] sv_load1,
  input  logic [XLEN_PIXEL-1:0] sv_load2,
  output logic [ACC_W-1:0]      kern1,
  output logic [ACC_W-1:0]      kern2,
  output logic [IDX_W-1:0]      sv_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done
);

  localparam int PW    = 2 * XLEN_PIXEL;
  localparam int PIX_W = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;
  localparam int SV_W  = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_OF_PIXELS - 1);
  localparam logic [SV_W-1:0]  SV_LAST  = SV_W'(NUM_OF_SV - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t           state;
  logic [PIX_W-1:0] pix_cnt;
  logic [SV_W-1:0]  sv_cnt;
  logic [ACC_W-1:0] acc1, acc2;
  logic [ACC_W-1:0] sum1, sum2;
  logic [PW-1:0]    term1, term2;
  logic             beat;

`ifdef SV_KERNEL_SQ_DIST_EN
  // |x - sv| squared equals the square of the signed XLEN_PIXEL+1 difference
  logic [XLEN_PIXEL-1:0] dist1, dist2;

  always_comb begin
    dist1 = (x_test >= sv_load1) ? (x_test - sv_load1) : (sv_load1 - x_test);
    dist2 = (x_test >= sv_load2) ? (x_test - sv_load2) : (sv_load2 - x_test);
  end

  assign term1 = PW'(dist1) * PW'(dist1);
  assign term2 = PW'(dist2) * PW'(dist2);
`else
  assign term1 = PW'(x_test) * PW'(sv_load1);
  assign term2 = PW'(x_test) * PW'(sv_load2);
`endif

  assign sum1     = acc1 + ACC_W'(term1);
  assign sum2     = acc2 + ACC_W'(term2);
  assign in_ready = (state == ACCUM) && !(out_valid && !out_ready);
  assign beat     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pix_cnt   <= '0;
      sv_cnt    <= '0;
      acc1      <= '0;
      acc2      <= '0;
      kern1     <= '0;
      kern2     <= '0;
      sv_idx    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // a result loaded below on the same edge overrides this clear
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (en) begin
            pix_cnt <= '0;
            sv_cnt  <= '0;
            acc1    <= '0;
            acc2    <= '0;
            state   <= ACCUM;
          end
        end

        ACCUM: begin
          if (beat) begin
            if (pix_cnt == PIX_LAST) begin
              kern1     <= sum1;
              kern2     <= sum2;
              sv_idx    <= IDX_W'(sv_cnt);
              out_valid <= 1'b1;
              acc1      <= '0;
              acc2      <= '0;
              pix_cnt   <= '0;
              sv_cnt    <= sv_cnt + 1'b1;
              if (sv_cnt == SV_LAST)
                state <= DRAIN;
            end else begin
              acc1    <= sum1;
              acc2    <= sum2;
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end

        DRAIN: begin
          if (out_valid && out_ready) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
